// File: rtl/uart_rx_cfg_if.sv
// Received-word stream between the UART receiver and its consumer (FIFO/CSR block).
// The receiver drives the word and its status flags; the consumer drives m_ready.
interface uart_rx_cfg_if #(
  parameter int MAX_DATA_BITS = 9
);
  logic [MAX_DATA_BITS-1:0] m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     parity_err;
  logic                     frame_err;
  logic                     break_det;
  logic                     overrun;

  modport master (
    output m_data, m_valid, parity_err, frame_err, break_det, overrun,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, parity_err, frame_err, break_det, overrun,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime frame format, 3-sample majority voting, break detection
// and a valid/ready output holding one word plus a sticky overrun flag.
module uart_rx_cfg #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVS_FACTOR    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_ovs,
  input  logic       rx_pin,
  input  logic [3:0] cfg_data_bits,
  input  logic [1:0] cfg_parity,
  input  logic       cfg_stop2,
  uart_rx_cfg_if.master m
);

  localparam int CW = $clog2(OVS_FACTOR);
  localparam logic [CW-1:0] OS_V0  = CW'(OVS_FACTOR / 2 - 1);
  localparam logic [CW-1:0] OS_V1  = CW'(OVS_FACTOR / 2);
  localparam logic [CW-1:0] OS_MID = CW'(OVS_FACTOR / 2 + 1);
  localparam logic [CW-1:0] OS_END = CW'(OVS_FACTOR - 1);

  if (OVS_FACTOR < 8 || (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_bad_ovs
    $fatal(1, "uart_rx_cfg: OVS_FACTOR must be a power of 2 and >= 8");
  end
  if (MAX_DATA_BITS < 5 || MAX_DATA_BITS > 9) begin : g_bad_bits
    $fatal(1, "uart_rx_cfg: MAX_DATA_BITS must be in 5..9");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, WAITHI
  } state_t;

  state_t                   state_q, state_d;
  logic                     rx_meta_q, rx_meta_d;
  logic                     rx_s_q, rx_s_d;
  logic [CW-1:0]            os_count_q, os_count_d;
  logic                     va_q, va_d;
  logic                     vb_q, vb_d;
  logic [3:0]               bit_idx_q, bit_idx_d;
  logic [3:0]               nbits_q, nbits_d;
  logic                     par_en_q, par_en_d;
  logic                     par_odd_q, par_odd_d;
  logic                     stop2_q, stop2_d;
  logic [MAX_DATA_BITS-1:0] data_q, data_d;
  logic                     par_q, par_d;
  logic                     stop1_q, stop1_d;

  logic [MAX_DATA_BITS-1:0] m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     parity_err_q, parity_err_d;
  logic                     frame_err_q, frame_err_d;
  logic                     break_det_q, break_det_d;
  logic                     overrun_q, overrun_d;

  logic vote, at_mid, at_end, complete, accept;
  logic stop1_v, stop2_ok, c_fe, c_bd, c_pe;

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = rx_pin;
    rx_s_d       = rx_meta_q;
    os_count_d   = os_count_q;
    va_d         = va_q;
    vb_d         = vb_q;
    bit_idx_d    = bit_idx_q;
    nbits_d      = nbits_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    stop2_d      = stop2_q;
    data_d       = data_q;
    par_d        = par_q;
    stop1_d      = stop1_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    overrun_d    = overrun_q;
    complete     = 1'b0;

    vote   = (va_q & vb_q) | (va_q & rx_s_q) | (vb_q & rx_s_q);
    at_mid = (os_count_q == OS_MID);
    at_end = (os_count_q == OS_END);

    // The last stop sample is still in flight when the frame completes at mid.
    stop1_v  = (state_q == STOP1) ? vote : stop1_q;
    stop2_ok = (state_q == STOP2) ? vote : 1'b1;
    c_fe     = ~stop1_v | ~stop2_ok;
    c_bd     = (data_q == '0) && (!par_en_q || !par_q) && !stop1_v;
    c_pe     = par_en_q & (^data_q ^ par_q ^ par_odd_q);

    if (tick_ovs) begin
      if (os_count_q == OS_V0) va_d = rx_s_q;
      if (os_count_q == OS_V1) vb_d = rx_s_q;
      os_count_d = os_count_q + CW'(1);
      case (state_q)
        IDLE: begin
          os_count_d = '0;
          if (!rx_s_q) begin
            state_d   = START;
            bit_idx_d = '0;
            data_d    = '0;
            stop2_d   = cfg_stop2;
            par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_odd_d = (cfg_parity == 2'b01);
            if (cfg_data_bits < 4'd5 || cfg_data_bits > 4'(MAX_DATA_BITS))
              nbits_d = 4'(MAX_DATA_BITS);
            else
              nbits_d = cfg_data_bits;
          end
        end
        START: begin
          if (at_mid && vote) begin
            state_d    = IDLE;
            os_count_d = '0;
          end else if (at_end) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (at_mid) data_d[bit_idx_q] = vote;
          if (at_end) begin
            if (bit_idx_q == nbits_q - 4'd1)
              state_d = par_en_q ? PARITY : STOP1;
            else
              bit_idx_d = bit_idx_q + 4'd1;
          end
        end
        PARITY: begin
          if (at_mid) par_d = vote;
          if (at_end) state_d = STOP1;
        end
        STOP1: begin
          if (at_mid) begin
            stop1_d = vote;
            if (!stop2_q) complete = 1'b1;
          end else if (at_end && stop2_q) begin
            state_d = STOP2;
          end
        end
        STOP2: begin
          if (at_mid) complete = 1'b1;
        end
        WAITHI: begin
          os_count_d = '0;
          if (rx_s_q) state_d = IDLE;
        end
        default: begin
          state_d    = IDLE;
          os_count_d = '0;
        end
      endcase
      if (complete) begin
        state_d    = c_fe ? WAITHI : IDLE;
        os_count_d = '0;
      end
    end

    // Output holding register: a word arriving while one is still held is dropped.
    accept = m_valid_q && m.m_ready;
    if (complete && (!m_valid_q || accept)) begin
      m_data_d     = data_q;
      parity_err_d = c_pe;
      frame_err_d  = c_fe;
      break_det_d  = c_bd;
      m_valid_d    = 1'b1;
      overrun_d    = 1'b0;
    end else begin
      if (accept) begin
        m_valid_d = 1'b0;
        overrun_d = 1'b0;
      end
      if (complete) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      os_count_q   <= '0;
      va_q         <= 1'b1;
      vb_q         <= 1'b1;
      bit_idx_q    <= '0;
      nbits_q      <= 4'(MAX_DATA_BITS);
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      stop2_q      <= 1'b0;
      data_q       <= '0;
      par_q        <= 1'b0;
      stop1_q      <= 1'b1;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      os_count_q   <= os_count_d;
      va_q         <= va_d;
      vb_q         <= vb_d;
      bit_idx_q    <= bit_idx_d;
      nbits_q      <= nbits_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      stop2_q      <= stop2_d;
      data_q       <= data_d;
      par_q        <= par_d;
      stop1_q      <= stop1_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      overrun_q    <= overrun_d;
    end
  end

  assign m.m_data     = m_data_q;
  assign m.m_valid    = m_valid_q;
  assign m.parity_err = parity_err_q;
  assign m.frame_err  = frame_err_q;
  assign m.break_det  = break_det_q;
  assign m.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: a vector table of frames plus hand-written
// sequences for glitch, break, overrun and mid-frame reset.
module tb_uart_rx_cfg;

  localparam int OVS = 16;

  logic       clk;
  logic       reset;
  logic       tick_ovs;
  logic       rx_pin;
  logic [3:0] cfg_data_bits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;

  uart_rx_cfg_if #(.MAX_DATA_BITS(9)) m_if ();

  uart_rx_cfg #(.MAX_DATA_BITS(9), .OVS_FACTOR(OVS)) dut (
    .clk           (clk),
    .reset         (reset),
    .tick_ovs      (tick_ovs),
    .rx_pin        (rx_pin),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .m             (m_if.master)
  );

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } word_t;

  typedef struct {
    string      name;
    logic [3:0] cfg_bits;
    int         nb;
    logic [1:0] par;
    logic       stop2;
    logic [8:0] word;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic [8:0] e_data;
    logic       e_pe;
    logic       e_fe;
    logic       e_bd;
  } vec_t;

  word_t mon_q[$];
  int    n_tests = 0;
  int    n_fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One oversample tick every second clock, so FSM gating by tick_ovs is exercised.
  initial begin
    tick_ovs = 1'b0;
    forever begin
      @(negedge clk);
      tick_ovs = ~tick_ovs;
    end
  end

  always @(negedge clk) begin
    if (!reset && m_if.m_valid && m_if.m_ready)
      mon_q.push_back('{m_if.m_data, m_if.parity_err, m_if.frame_err, m_if.break_det});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_point();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!tick_ovs);
    end
  endtask

  task automatic send_level(input logic b, input int nbits);
    drive_point();
    rx_pin = b;
    wait_ticks(OVS * nbits);
  endtask

  task automatic send_data(input int nb, input logic [8:0] word);
    for (int i = 0; i < nb; i++) send_level(word[i], 1);
  endtask

  task automatic expect_word(input string name, input logic [8:0] e_data,
                             input logic e_pe, input logic e_fe, input logic e_bd);
    int    waited;
    word_t w;
    waited = 0;
    while (mon_q.size() == 0 && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    if (mon_q.size() == 0) begin
      n_tests++;
      n_fails++;
      $display("FAIL %s: no word within 4000 clks, expected data 0x%03h", name, e_data);
    end else begin
      w = mon_q.pop_front();
      $display("[TB] %s: data=0x%03h pe=%0b fe=%0b bd=%0b", name, w.data, w.pe, w.fe, w.bd);
      check({name, " data"}, 32'(w.data), 32'(e_data));
      check({name, " parity_err"}, 32'(w.pe), 32'(e_pe));
      check({name, " frame_err"}, 32'(w.fe), 32'(e_fe));
      check({name, " break_det"}, 32'(w.bd), 32'(e_bd));
    end
  endtask

  task automatic apply_reset(input int nclk);
    drive_point();
    reset = 1'b1;
    repeat (nclk) @(posedge clk);
    @(negedge clk);
    check("reset m_valid", 32'(m_if.m_valid), 32'd0);
    check("reset m_data", 32'(m_if.m_data), 32'd0);
    check("reset flags", {28'd0, m_if.parity_err, m_if.frame_err, m_if.break_det, m_if.overrun}, 32'd0);
    drive_point();
    reset = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    reset         = 1'b1;
    rx_pin        = 1'b1;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    m_if.m_ready  = 1'b1;

    //             name        cfg    nb par    st2   word    pbit  s1    s2    e_data  pe    fe    bd
    vecs[0] = '{"8N1 A5",     4'd8,  8, 2'b00, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"9E1 1C3 ok", 4'd9,  9, 2'b10, 1'b0, 9'h1C3, 1'b1, 1'b1, 1'b1, 9'h1C3, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"9E1 1C3 pe", 4'd9,  9, 2'b10, 1'b0, 9'h1C3, 1'b0, 1'b1, 1'b1, 9'h1C3, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"7O2 bad s2", 4'd7,  7, 2'b01, 1'b1, 9'h000, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"5E2 15",     4'd5,  5, 2'b10, 1'b1, 9'h015, 1'b1, 1'b1, 1'b1, 9'h015, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"cfg15 155",  4'd15, 9, 2'b11, 1'b0, 9'h155, 1'b0, 1'b1, 1'b1, 9'h155, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"6O1 3F pe",  4'd6,  6, 2'b01, 1'b0, 9'h03F, 1'b0, 1'b1, 1'b1, 9'h03F, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"8N1 bad s1", 4'd8,  8, 2'b00, 1'b0, 9'h080, 1'b0, 1'b0, 1'b1, 9'h080, 1'b0, 1'b1, 1'b0};

    apply_reset(4);
    send_level(1'b1, 2);

    foreach (vecs[i]) begin
      drive_point();
      cfg_data_bits = vecs[i].cfg_bits;
      cfg_parity    = vecs[i].par;
      cfg_stop2     = vecs[i].stop2;
      send_level(1'b0, 1);
      send_data(vecs[i].nb, vecs[i].word);
      if (vecs[i].par == 2'b01 || vecs[i].par == 2'b10) send_level(vecs[i].pbit, 1);
      send_level(vecs[i].s1, 1);
      if (vecs[i].stop2) send_level(vecs[i].s2, 1);
      send_level(1'b1, 2);
      expect_word(vecs[i].name, vecs[i].e_data, vecs[i].e_pe, vecs[i].e_fe, vecs[i].e_bd);
      check({vecs[i].name, " extra words"}, 32'(mon_q.size()), 32'd0);
    end

    // Format change after the start bit must not affect the frame in flight.
    drive_point();
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    send_level(1'b0, 1);
    cfg_data_bits = 4'd5; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    send_data(8, 9'h0A5);
    send_level(1'b1, 3);
    expect_word("cfg latch", 9'h0A5, 1'b0, 1'b0, 1'b0);
    drive_point();
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;

    // Break: line low for 20 bit times gives exactly one word.
    send_level(1'b0, 20);
    expect_word("break", 9'h000, 1'b0, 1'b1, 1'b1);
    check("break extra low", 32'(mon_q.size()), 32'd0);
    send_level(1'b1, 3);
    check("break extra high", 32'(mon_q.size()), 32'd0);

    // Short glitch on the start bit is rejected; the next frame is received normally.
    drive_point();
    rx_pin = 1'b0;
    wait_ticks(4);
    send_level(1'b1, 3);
    check("glitch no word", 32'(mon_q.size()), 32'd0);
    send_level(1'b0, 1);
    send_data(8, 9'h03C);
    send_level(1'b1, 2);
    expect_word("after glitch", 9'h03C, 1'b0, 1'b0, 1'b0);

    // Overrun: second frame dropped while the first is held.
    drive_point();
    m_if.m_ready = 1'b0;
    send_level(1'b0, 1); send_data(8, 9'h011); send_level(1'b1, 2);
    send_level(1'b0, 1); send_data(8, 9'h022); send_level(1'b1, 2);
    @(negedge clk);
    $display("[TB] overrun held: data=0x%03h valid=%0b overrun=%0b", m_if.m_data, m_if.m_valid, m_if.overrun);
    check("ovr valid held", 32'(m_if.m_valid), 32'd1);
    check("ovr data held", 32'(m_if.m_data), 32'h011);
    check("ovr flag", 32'(m_if.overrun), 32'd1);
    drive_point();
    m_if.m_ready = 1'b1;
    drive_point();
    m_if.m_ready = 1'b0;
    @(negedge clk);
    check("ovr valid after accept", 32'(m_if.m_valid), 32'd0);
    check("ovr cleared", 32'(m_if.overrun), 32'd0);
    expect_word("ovr accepted", 9'h011, 1'b0, 1'b0, 1'b0);
    check("ovr no 22", 32'(mon_q.size()), 32'd0);

    // Reset mid-frame with a word held: everything clears, nothing emitted.
    send_level(1'b0, 1); send_data(8, 9'h077); send_level(1'b1, 2);
    @(negedge clk);
    check("pre-reset valid", 32'(m_if.m_valid), 32'd1);
    send_level(1'b0, 1); send_data(3, 9'h005);
    apply_reset(3);
    rx_pin = 1'b1;
    m_if.m_ready = 1'b1;
    send_level(1'b1, 12);
    @(negedge clk);
    check("post-reset valid", 32'(m_if.m_valid), 32'd0);
    check("post-reset no word", 32'(mon_q.size()), 32'd0);
    send_level(1'b0, 1); send_data(8, 9'h0A5); send_level(1'b1, 2);
    expect_word("post-reset A5", 9'h0A5, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
